// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: data width, NOP encoding, IF/ID payload, fetch entry and IF state.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_t;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } if_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched {pc, instr} while decode is stalled.
module if_skid_buf
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load_i,
    input  logic   unload_i,
    input  logic   clear_i,
    input  fetch_t data_i,
    output logic   full_o,
    output fetch_t data_o
);

    logic   full_q;
    fetch_t data_q;

    // Clear (redirect) beats load; data is only written on a live load.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (clear_i) begin
                full_q <= 1'b0;
            end else if (load_i) begin
                full_q <= 1'b1;
            end else if (unload_i) begin
                full_q <= 1'b0;
            end
            if (load_i && !clear_i) begin
                data_q <= data_i;
            end
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register and skid buffer for decode stalls.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_id,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;

    logic   skid_load, skid_unload, skid_clear, skid_full;
    fetch_t skid_wdata, skid_rdata;

    assign skid_wdata = '{pc: pc_q, instr: imem_rdata};

    if_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .data_i   (skid_wdata),
        .full_o   (skid_full),
        .data_o   (skid_rdata)
    );

    // Next-state: redirect first, then fetch/hold handling.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_d      = ifid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        if (redirect_valid) begin
            pc_d         = redirect_pc & PC_ALIGN;
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
            skid_clear   = 1'b1;
            state_d      = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_q + PC_STEP;
                        if (stall_id) begin
                            skid_load = 1'b1;
                            state_d   = ST_HOLD;
                        end else begin
                            ifid_d = '{valid: 1'b1, pc: pc_q, instr: imem_rdata};
                        end
                    end else if (!stall_id) begin
                        ifid_d.valid = 1'b0;
                        ifid_d.instr = NOP_INSTR;
                    end
                end
                ST_HOLD: begin
                    if (!stall_id) begin
                        skid_unload = 1'b1;
                        state_d     = ST_FETCH;
                        if (skid_full) begin
                            ifid_d = '{valid: 1'b1, pc: skid_rdata.pc, instr: skid_rdata.instr};
                        end
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ifid_q  <= '{valid: 1'b0, pc: RESET_PC, instr: NOP_INSTR};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign id_valid  = ifid_q.valid;
    assign id_pc     = ifid_q.pc;
    assign id_instr  = ifid_q.instr;

`ifdef IF_PERF_CNT_EN
    logic        fetch_inc;
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    // Counts both direct accepts and skid captures.
    assign fetch_inc = !redirect_valid && (state_q == ST_FETCH) && imem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_q + 32'(fetch_inc);
            bubble_cnt_q <= bubble_cnt_q + 32'(!ifid_d.valid);
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; perf counter test active when IF_PERF_CNT_EN is defined.
module tb_if_stage;

    localparam logic [31:0] K   = 32'h5A5A_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    // Memory returns a unique word per address.
    assign imem_rdata = imem_addr ^ K;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        stall_id = 1'b0; imem_ready = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== NOP) begin
            errors++;
            $display("FAIL reset_ifid got v=%b pc=%h in=%h exp v=0 pc=0 in=%h", id_valid, id_pc, id_instr, NOP);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_imem got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            e = 32'(i * 4);
            checks++;
            if (id_valid !== 1'b1 || id_pc !== e || id_instr !== (e ^ K)) begin
                errors++;
                $display("FAIL stream_%0d got v=%b pc=%h in=%h exp v=1 pc=%h in=%h", i, id_valid, id_pc, id_instr, e, e ^ K);
            end
        end
    endtask

    task automatic test_bubble();
        do_reset();
        imem_ready = 1'b1;
        cycle(); cycle();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h4 || imem_addr !== 32'h8) begin
                errors++;
                $display("FAIL bubble_%0d got v=%b pc=%h in=%h addr=%h exp v=0 pc=4 in=%h addr=8", i, id_valid, id_pc, id_instr, imem_addr, NOP);
            end
        end
        stall_id = 1'b1;
        cycle();
        checks++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h8 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL notready_stall got v=%b addr=%h req=%b exp v=0 addr=8 req=1", id_valid, imem_addr, imem_req);
        end
        stall_id = 1'b0; imem_ready = 1'b1;
        cycle();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== (32'h8 ^ K)) begin
            errors++;
            $display("FAIL bubble_resume got v=%b pc=%h in=%h exp v=1 pc=8 in=%h", id_valid, id_pc, id_instr, 32'h8 ^ K);
        end
        cycle();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'hC) begin
            errors++;
            $display("FAIL bubble_nodup got v=%b pc=%h exp v=1 pc=c", id_valid, id_pc);
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        do_reset();
        imem_ready = 1'b1;
        repeat (4) cycle();
        stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'hC || imem_req !== 1'b0 || imem_addr !== 32'h14) begin
                errors++;
                $display("FAIL stall_hold_%0d got v=%b pc=%h req=%b addr=%h exp v=1 pc=c req=0 addr=14", i, id_valid, id_pc, imem_req, imem_addr);
            end
        end
        stall_id = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            e = 32'h10 + 32'(i * 4);
            checks++;
            if (id_valid !== 1'b1 || id_pc !== e || id_instr !== (e ^ K) || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL stall_release_%0d got v=%b pc=%h in=%h req=%b exp v=1 pc=%h in=%h req=1", i, id_valid, id_pc, id_instr, imem_req, e, e ^ K);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_ready = 1'b1;
        cycle();
        stall_id = 1'b1;
        cycle();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_enter_hold got req=%b exp req=0", imem_req);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        cycle();
        checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL redir_flush got v=%b in=%h addr=%h req=%b exp v=0 in=%h addr=100 req=1", id_valid, id_instr, imem_addr, imem_req, NOP);
        end
        redirect_valid = 1'b0; stall_id = 1'b0;
        cycle();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== (32'h100 ^ K)) begin
            errors++;
            $display("FAIL redir_first got v=%b pc=%h in=%h exp v=1 pc=100 in=%h", id_valid, id_pc, id_instr, 32'h100 ^ K);
        end
        cycle();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h104) begin
            errors++;
            $display("FAIL redir_second got v=%b pc=%h exp v=1 pc=104", id_valid, id_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cycle();
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_align got addr=%h v=%b exp addr=fffffffc v=0", imem_addr, id_valid);
        end
        redirect_valid = 1'b0;
        cycle();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc got v=%b pc=%h addr=%h exp v=1 pc=fffffffc addr=0", id_valid, id_pc, imem_addr);
        end
        cycle();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== K) begin
            errors++;
            $display("FAIL wrap_next got v=%b pc=%h in=%h exp v=1 pc=0 in=%h", id_valid, id_pc, id_instr, K);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        imem_ready = 1'b1;
        cycle();
        stall_id = 1'b1;
        cycle();
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        cycle();
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== NOP || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold got v=%b pc=%h in=%h addr=%h req=%b exp v=0 pc=0 in=%h addr=0 req=1", id_valid, id_pc, id_instr, imem_addr, imem_req, NOP);
        end
        reset = 1'b0; redirect_valid = 1'b0; stall_id = 1'b0;
        cycle();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_hold_first got v=%b pc=%h exp v=1 pc=0", id_valid, id_pc);
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        logic [3:0]  pat;
        int unsigned ef;
        int unsigned eb;
        do_reset();
        checks++;
        if (perf_fetch_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0) begin
            errors++;
            $display("FAIL perf_reset got f=%0d b=%0d exp 0 0", perf_fetch_cnt, perf_bubble_cnt);
        end
        ef = 0; eb = 0;
        pat = 4'b1100;
        for (int i = 0; i < 6; i++) begin
            imem_ready = (i < 2 || i > 3) ? 1'b1 : pat[0];
            cycle();
            if (imem_ready) ef++; else eb++;
        end
        checks++;
        if (perf_fetch_cnt !== 32'(ef) || perf_bubble_cnt !== 32'(eb) || ef != 4 || eb != 2) begin
            errors++;
            $display("FAIL perf_bubble got f=%0d b=%0d exp f=%0d b=%0d", perf_fetch_cnt, perf_bubble_cnt, ef, eb);
        end
        stall_id = 1'b1;
        cycle(); cycle();
        stall_id = 1'b0;
        cycle();
        checks++;
        if (perf_fetch_cnt !== 32'd5 || perf_bubble_cnt !== 32'd2) begin
            errors++;
            $display("FAIL perf_stall got f=%0d b=%0d exp f=5 b=2", perf_fetch_cnt, perf_bubble_cnt);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (perf_fetch_cnt !== 32'd5 || perf_bubble_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_redir got f=%0d b=%0d exp f=5 b=3", perf_fetch_cnt, perf_bubble_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_bubble();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_in_hold();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, encoding driven on id_instr for a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address (current PC).
REQ-007 imem_ready  input  1  memory returns imem_rdata for the imem_addr presented in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction; valid only when imem_req && imem_ready.
REQ-009 stall_id  input  1  decode cannot accept; the IF/ID register holds its value.
REQ-010 redirect_valid  input  1  branch/jump resolved taken; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 0.
REQ-012 id_valid  output  1  IF/ID register holds a real instruction.
REQ-013 id_pc  output  32  PC of the instruction in IF/ID.
REQ-014 id_instr  output  32  instruction in IF/ID, or NOP_INSTR when id_valid=0.

Function
REQ-015 The stage SHALL have states FETCH (imem_req=1) and HOLD (imem_req=0, one-entry skid buffer full).
REQ-016 In FETCH, accept = imem_ready && !stall_id: IF/ID <= {1, pc, imem_rdata}, and pc <= pc+4 with 32-bit wrap-around.
REQ-017 In FETCH with imem_ready=0 and stall_id=0, IF/ID SHALL load a bubble (id_valid=0, id_instr=NOP_INSTR, id_pc unchanged), and pc SHALL hold.
REQ-018 In FETCH with imem_ready=1 and stall_id=1, the stage SHALL capture {pc, imem_rdata} into the skid buffer, set pc <= pc+4, hold IF/ID, and enter HOLD.
REQ-019 In FETCH with imem_ready=0 and stall_id=1, IF/ID and pc SHALL hold.
REQ-020 In HOLD with stall_id=1, everything SHALL hold. With stall_id=0, the skid buffer SHALL move to IF/ID with id_valid=1, the buffer empties, and the state returns to FETCH.
REQ-021 Fetch-to-decode latency SHALL be one cycle: data accepted at edge N is visible on id_* after edge N.
REQ-022 redirect_valid SHALL have priority over stall_id and imem_ready: pc <= {redirect_pc[31:2],2'b00}, id_valid <= 0, id_instr <= NOP_INSTR, skid buffer discarded, state <= FETCH; any same-cycle imem response is dropped.
REQ-023 imem_addr SHALL equal the pc register at all times; imem_req SHALL be 1 exactly in FETCH.
REQ-024 The stage SHALL never drop or duplicate an instruction absent redirect; the order to decode is strictly sequential PC.

Reset
REQ-025 On reset: pc=RESET_PC, state=FETCH, id_valid=0, id_pc=RESET_PC, id_instr=NOP_INSTR, skid buffer empty.
REQ-026 Reset SHALL override redirect, stall and any in-progress HOLD in the same cycle.
REQ-027 imem_req SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 With IF_PERF_CNT_EN defined, the stage SHALL add outputs perf_fetch_cnt[31:0] (increments on each accepted or skid-captured fetch) and perf_bubble_cnt[31:0] (increments each cycle id_valid is 0 after the edge). Both counters are reset to 0 and wrap at 2^32.
REQ-029 Without IF_PERF_CNT_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 A shared package cpu_pkg SHALL hold XLEN=32, the NOP encoding constant, and the IF/ID payload struct {valid, pc, instr}.
REQ-031 The skid buffer SHALL be a sub-module if_skid_buf (one entry, load/unload/clear).

Verification
REQ-032 Reset, then imem_ready=1 continuously with no stall: id_pc sequences 0,4,8,12 on consecutive cycles with id_valid=1.
REQ-033 imem_ready=0 for 2 cycles at pc=8: two bubbles appear (id_valid=0, id_instr=32'h13), then pc=8 is delivered once.
REQ-034 stall_id=1 for 3 cycles with imem_ready=1 at pc=0x10: IF/ID holds 0x0C, state=HOLD, imem_req=0; after release, id_pc=0x10 then 0x14, with no loss or duplication.
REQ-035 redirect_valid=1 with redirect_pc=0x103 while in HOLD: next id_valid=0, imem_addr=0x100, and the first delivered id_pc is 0x100.
REQ-036 Reset asserted mid-HOLD with redirect_valid=1: post-reset values per REQ-025, and imem_addr=RESET_PC.
REQ-037 With IF_PERF_CNT_EN, run REQ-033 from reset: perf_fetch_cnt and perf_bubble_cnt match the scoreboarded counts; pc at 0xFFFF_FFFC wraps to 0.
